// File: rtl/conv_loader_pkg.sv
// conv_loader_pkg: shared defaults, FSM state type and TUSER header layout
package conv_loader_pkg;
  localparam int DEF_INW = 12;
  localparam int DEF_R_MAX = 64;
  localparam int DEF_C_MAX = 64;
  localparam int DEF_K = 4;
  localparam int HDR_RW = $clog2(DEF_R_MAX + 1);
  localparam int HDR_CW = $clog2(DEF_C_MAX + 1);
  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_X, DONE} state_t;
  typedef struct packed {
    logic              new_w;
    logic [HDR_RW-1:0] r;
    logic [HDR_CW-1:0] c;
  } hdr_t;
endpackage

// File: rtl/loader_ram.sv
// loader_ram: one write port, one registered read port, no reset
module loader_ram #(
  parameter int WIDTH = 12,
  parameter int SIZE = 16,
  localparam int AW = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [SIZE];
  logic [WIDTH-1:0] rdata_q;
  // write when enabled; read data lands one cycle after the address
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/conv_input_loader.sv
// conv_input_loader: AXI-Stream sink storing a W/X frame for the conv datapath; INLOAD_HDR_CHECK_EN enables header checking
module conv_input_loader import conv_loader_pkg::*; #(
  parameter int INW = DEF_INW,
  parameter int R_MAX = DEF_R_MAX,
  parameter int C_MAX = DEF_C_MAX,
  parameter int K = DEF_K,
  localparam int RW = $clog2(R_MAX + 1),
  localparam int CW = $clog2(C_MAX + 1),
  localparam int XAW = $clog2(R_MAX * C_MAX),
  localparam int WAW = $clog2(K * K)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INW-1:0]   INPUT_TDATA,
  input  logic             INPUT_TVALID,
  input  logic [RW+CW:0]   INPUT_TUSER,
  output logic             INPUT_TREADY,
  output logic             inputs_loaded,
  output logic [RW-1:0]    R,
  output logic [CW-1:0]    C,
  input  logic [XAW-1:0]   X_read_addr,
  output logic [INW-1:0]   X_data,
  input  logic [WAW-1:0]   W_read_addr,
  output logic [INW-1:0]   W_data,
  input  logic             compute_finished,
  output logic             hdr_err
);
  localparam int KK = K * K;
  state_t state_q, state_d;
  logic [XAW:0] x_cnt_q, x_cnt_d, x_total;
  logic [WAW:0] w_cnt_q, w_cnt_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic accept, x_we, w_we, x_last, w_last, hdr_bad;
  hdr_t hdr;
  assign hdr = INPUT_TUSER;
  assign INPUT_TREADY = state_q != DONE;
  assign inputs_loaded = state_q == DONE;
  assign accept = INPUT_TVALID && INPUT_TREADY;
  assign R = r_q;
  assign C = c_q;
  assign x_total = (state_q == IDLE) ? (XAW+1)'(hdr.r) * (XAW+1)'(hdr.c) : (XAW+1)'(r_q) * (XAW+1)'(c_q);
  assign x_last = x_cnt_q == x_total - 1'b1;
  assign w_last = w_cnt_q == (WAW+1)'(KK - 1);
`ifdef INLOAD_HDR_CHECK_EN
  logic hdr_err_q, hdr_err_d, w_loaded_q, w_loaded_d;
  assign hdr_bad = hdr.r < RW'(K) || hdr.r > RW'(R_MAX) || hdr.c < CW'(K) || hdr.c > CW'(C_MAX) || (!hdr.new_w && !w_loaded_q);
  // sticky error on a dropped header; remember that a full W set exists
  always_comb begin
    hdr_err_d = hdr_err_q | (state_q == IDLE && accept && hdr_bad);
    w_loaded_d = w_loaded_q | (w_we && w_last);
  end
  // check-state registers
  always_ff @(posedge clk) begin
    hdr_err_q <= reset ? 1'b0 : hdr_err_d;
    w_loaded_q <= reset ? 1'b0 : w_loaded_d;
  end
  assign hdr_err = hdr_err_q;
`else
  assign hdr_bad = 1'b0;
  assign hdr_err = 1'b0;
`endif
  // frame sequencing: header in IDLE, K*K weights, R*C inputs, hold until released
  always_comb begin
    state_d = state_q;
    x_cnt_d = x_cnt_q;
    w_cnt_d = w_cnt_q;
    r_d = r_q;
    c_d = c_q;
    x_we = 1'b0;
    w_we = 1'b0;
    case (state_q)
      IDLE: if (accept && !hdr_bad) begin
        r_d = hdr.r;
        c_d = hdr.c;
        w_we = hdr.new_w;
        x_we = !hdr.new_w;
        w_cnt_d = hdr.new_w ? w_cnt_q + 1'b1 : w_cnt_q;
        x_cnt_d = hdr.new_w ? x_cnt_q : x_cnt_q + 1'b1;
        state_d = hdr.new_w ? ((KK == 1) ? LOAD_X : LOAD_W) : (x_last ? DONE : LOAD_X);
      end
      LOAD_W: if (accept) begin
        w_we = 1'b1;
        w_cnt_d = w_cnt_q + 1'b1;
        state_d = w_last ? LOAD_X : LOAD_W;
      end
      LOAD_X: if (accept) begin
        x_we = 1'b1;
        x_cnt_d = x_cnt_q + 1'b1;
        state_d = x_last ? DONE : LOAD_X;
      end
      DONE: if (compute_finished) begin
        state_d = IDLE;
        x_cnt_d = '0;
        w_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, counters and latched header
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_cnt_q <= '0;
      w_cnt_q <= '0;
      r_q <= '0;
      c_q <= '0;
    end else begin
      state_q <= state_d;
      x_cnt_q <= x_cnt_d;
      w_cnt_q <= w_cnt_d;
      r_q <= r_d;
      c_q <= c_d;
    end
  end
  loader_ram #(.WIDTH(INW), .SIZE(R_MAX * C_MAX)) u_x_ram (
    .clk(clk), .we(x_we), .waddr(x_cnt_q[XAW-1:0]), .wdata(INPUT_TDATA),
    .raddr(X_read_addr), .rdata(X_data)
  );
  loader_ram #(.WIDTH(INW), .SIZE(KK)) u_w_ram (
    .clk(clk), .we(w_we), .waddr(w_cnt_q[WAW-1:0]), .wdata(INPUT_TDATA),
    .raddr(W_read_addr), .rdata(W_data)
  );
endmodule

// File: tb/tb_conv_input_loader.sv
// tb_conv_input_loader: frame-level scoreboard bench for conv_input_loader
module tb_conv_input_loader;
  localparam int KK = 16;
  logic clk = 1'b0;
  logic reset, tvalid, cf, tready, loaded, hdr_err;
  logic [11:0] tdata, xra, xd, wd;
  logic [14:0] tuser;
  logic [6:0] r_o, c_o;
  logic [3:0] wra;
  logic [11:0] wm [KK];
  logic [11:0] xm [4096];
  int pass_n = 0, total_n = 0;
  typedef struct {bit isx; int addr; logic [11:0] exp;} vec_t;
  vec_t tbl [6];
  always #5 clk = ~clk;
  conv_input_loader dut (
    .clk(clk), .reset(reset), .INPUT_TDATA(tdata), .INPUT_TVALID(tvalid), .INPUT_TUSER(tuser),
    .INPUT_TREADY(tready), .inputs_loaded(loaded), .R(r_o), .C(c_o),
    .X_read_addr(xra), .X_data(xd), .W_read_addr(wra), .W_data(wd),
    .compute_finished(cf), .hdr_err(hdr_err)
  );
  function automatic logic [11:0] f(int i);
    return 12'(i * 173 + 11);
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
  endtask
  // stream one frame; the model decides which RAM/address each accepted beat belongs to
  task automatic send_frame(input bit nw, input int r, input int c, input int duty, input bit rnd, input int stop_after, input bit pulse_cf);
    int total, lim, sent, cyc;
    logic [11:0] d;
    total = (nw ? KK : 0) + r * c;
    lim = (stop_after >= 0 && stop_after < total) ? stop_after : total;
    sent = 0;
    cyc = 0;
    while (sent < lim && cyc < 3000) begin
      chk("tready_loading", tready, 1);
      chk("loaded_loading", loaded, 0);
      tvalid = $urandom_range(99) < duty;
      d = rnd ? 12'($urandom) : f(sent);
      tdata = d;
      tuser = {nw, r[6:0], c[6:0]};
      cf = pulse_cf && $urandom_range(1) == 1;
      @(posedge clk);
      if (tvalid) begin
        if (nw && sent < KK) wm[sent] = d;
        else xm[sent - (nw ? KK : 0)] = d;
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    tvalid = 1'b0;
    cf = 1'b0;
    if (cyc >= 3000) chk("frame_timeout", sent, lim);
    if (lim == total) begin
      for (int i = 0; i < 3; i++) begin
        chk("tready_done", tready, 0);
        chk("loaded_done", loaded, 1);
        tvalid = 1'b1;
        tdata = 12'($urandom);
        @(negedge clk);
      end
      tvalid = 1'b0;
    end
  endtask
  task automatic rd(input bit isx, input int a, input logic [11:0] exp, input string nm);
    if (isx) xra = 12'(a);
    else wra = 4'(a);
    @(negedge clk);
    chk(nm, isx ? xd : wd, exp);
  endtask
  task automatic check_frame(input int r, input int c);
    for (int i = 0; i < KK; i++) rd(1'b0, i, wm[i], "w_ram");
    for (int i = 0; i < r * c; i++) rd(1'b1, i, xm[i], "x_ram");
    chk("latched_R", r_o, r);
    chk("latched_C", c_o, c);
  endtask
  task automatic release_frame();
    cf = 1'b1;
    @(negedge clk);
    cf = 1'b0;
    chk("release_tready", tready, 1);
    chk("release_loaded", loaded, 0);
  endtask
  initial begin
    tbl[0] = '{1'b0, 5, f(5)};
    tbl[1] = '{1'b1, 15, f(31)};
    tbl[2] = '{1'b0, 0, f(0)};
    tbl[3] = '{1'b0, 15, f(15)};
    tbl[4] = '{1'b1, 0, f(16)};
    tbl[5] = '{1'b1, 7, f(23)};
    reset = 1'b1;
    tvalid = 1'b0;
    cf = 1'b0;
    tdata = '0;
    tuser = '0;
    xra = '0;
    wra = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_tready", tready, 1);
    chk("reset_loaded", loaded, 0);
    chk("reset_R", r_o, 0);
    chk("reset_C", c_o, 0);
    chk("reset_hdr_err", hdr_err, 0);
    send_frame(1'b1, 4, 4, 100, 1'b0, -1, 1'b0);
    for (int i = 0; i < 6; i++) rd(tbl[i].isx, tbl[i].addr, tbl[i].exp, tbl[i].isx ? "tbl_x" : "tbl_w");
    check_frame(4, 4);
    release_frame();
    send_frame(1'b0, 5, 6, 100, 1'b1, -1, 1'b0);
    rd(1'b0, 0, f(0), "reuse_w0");
    check_frame(5, 6);
    release_frame();
    send_frame(1'b1, 6, 4, 40, 1'b1, -1, 1'b1);
    check_frame(6, 4);
    release_frame();
    send_frame(1'b1, 4, 4, 100, 1'b1, 10, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_tready", tready, 1);
    chk("midreset_loaded", loaded, 0);
    chk("midreset_R", r_o, 0);
    chk("midreset_C", c_o, 0);
`ifdef INLOAD_HDR_CHECK_EN
    tvalid = 1'b1;
    tdata = 12'($urandom);
    tuser = {1'b0, 7'd4, 7'd4};
    @(negedge clk);
    tvalid = 1'b0;
    chk("hdr_tready", tready, 1);
    chk("hdr_loaded", loaded, 0);
    chk("hdr_err_set", hdr_err, 1);
    @(negedge clk);
    chk("hdr_err_sticky", hdr_err, 1);
`endif
    send_frame(1'b1, 4, 4, 100, 1'b1, -1, 1'b0);
    check_frame(4, 4);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
